// File: rtl/manual_entry_pkg.sv
// Shared types and defaults for the manual word-entry path.
package manual_entry_pkg;

  typedef enum logic [0:0] {SHIFT, HOLD} entry_state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/manual_word_entry.sv
// Shifts one debounced bit per manualClk edge, MSB-first, and offers each full word to a
// downstream consumer over a valid/ready handshake; also exposes entry progress for display.
module manual_word_entry
  import manual_entry_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     manualClk,
  input  logic                     rst,
  input  logic                     bitIn,
  input  logic                     clear,
  input  logic                     ready,
  output logic                     wordValid,
  output logic [WIDTH-1:0]         word,
  output logic [WIDTH-1:0]         partial,
  output logic [$clog2(WIDTH)-1:0] bitCount,
  output logic [CNT_W-1:0]         wordCount,
  output logic                     overrun
);

  localparam int unsigned BcW = $clog2(WIDTH);
  localparam logic [BcW-1:0] LastBit = BcW'(WIDTH - 1);

  entry_state_t     state_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] word_q;
  logic [BcW-1:0]   bit_count_q;
  logic [CNT_W-1:0] word_count_q;
  logic             valid_q;
  logic             overrun_q;

  always_ff @(posedge manualClk or posedge rst) begin
    if (rst) begin
      state_q      <= SHIFT;
      partial_q    <= '0;
      word_q       <= '0;
      bit_count_q  <= '0;
      word_count_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (clear) begin
            partial_q   <= '0;
            bit_count_q <= '0;
          end else if (bit_count_q == LastBit) begin
            // Completing edge: word is published on the same edge as the last shift.
            word_q      <= {partial_q[WIDTH-2:0], bitIn};
            valid_q     <= 1'b1;
            partial_q   <= '0;
            bit_count_q <= '0;
            state_q     <= HOLD;
          end else begin
            partial_q   <= {partial_q[WIDTH-2:0], bitIn};
            bit_count_q <= bit_count_q + BcW'(1);
          end
        end
        HOLD: begin
          if (ready) begin
            valid_q      <= 1'b0;
            word_count_q <= word_count_q + CNT_W'(1);
            state_q      <= SHIFT;
            // The accepting press also carries the first bit of the next word.
            if (clear) begin
              partial_q   <= '0;
              bit_count_q <= '0;
            end else begin
              partial_q   <= {{(WIDTH-1){1'b0}}, bitIn};
              bit_count_q <= BcW'(1);
            end
          end else if (clear) begin
            partial_q   <= '0;
            bit_count_q <= '0;
          end else begin
            overrun_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign wordValid = valid_q;
  assign word      = word_q;
  assign partial   = partial_q;
  assign bitCount  = bit_count_q;
  assign wordCount = word_count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_manual_word_entry.sv
// Bench for manual_word_entry: reference model per press plus a scoreboard of completed words.
module tb_manual_word_entry;

  logic        manualClk = 1'b0;
  logic        rst = 1'b0;
  logic        bitIn = 1'b0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  logic        wordValid;
  logic [15:0] word;
  logic [15:0] partial;
  logic [3:0]  bitCount;
  logic [7:0]  wordCount;
  logic        overrun;

  manual_word_entry #(
    .WIDTH(16),
    .CNT_W(8)
  ) dut (
    .manualClk(manualClk),
    .rst      (rst),
    .bitIn    (bitIn),
    .clear    (clear),
    .ready    (ready),
    .wordValid(wordValid),
    .word     (word),
    .partial  (partial),
    .bitCount (bitCount),
    .wordCount(wordCount),
    .overrun  (overrun)
  );

  always #5 manualClk = ~manualClk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference state
  logic        m_hold;
  logic        m_valid;
  logic [15:0] m_word;
  logic [15:0] m_partial;
  int unsigned m_cnt;
  logic [7:0]  m_wc;
  logic        m_ov;
  logic        prev_valid;
  logic [15:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_valid = 0; m_word = '0; m_partial = '0;
    m_cnt = 0; m_wc = '0; m_ov = 0; prev_valid = 0;
    sb_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"},   32'(wordValid), 32'(m_valid));
    check_eq({tag, ".word"},    32'(word),      32'(m_word));
    check_eq({tag, ".partial"}, 32'(partial),   32'(m_partial));
    check_eq({tag, ".bitcnt"},  32'(bitCount),  m_cnt);
    check_eq({tag, ".wordcnt"}, 32'(wordCount), 32'(m_wc));
    check_eq({tag, ".overrun"}, 32'(overrun),   32'(m_ov));
  endtask

  // One debounced press: drive, clock, advance model, sample 1 time unit after the edge.
  task automatic press(input logic b, input logic clr, input logic rdy);
    logic [15:0] sb_word;
    bitIn = b; clear = clr; ready = rdy;
    @(posedge manualClk);
    if (m_hold) begin
      if (rdy) begin
        m_valid = 0; m_wc = m_wc + 8'd1; m_hold = 0;
        if (clr) begin m_partial = '0; m_cnt = 0; end
        else begin m_partial = {15'd0, b}; m_cnt = 1; end
      end else if (clr) begin
        m_partial = '0; m_cnt = 0;
      end else begin
        m_ov = 1;
      end
    end else if (clr) begin
      m_partial = '0; m_cnt = 0;
    end else if (m_cnt == 15) begin
      m_word = {m_partial[14:0], b};
      sb_q.push_back(m_word);
      m_valid = 1; m_partial = '0; m_cnt = 0; m_hold = 1;
    end else begin
      m_partial = {m_partial[14:0], b};
      m_cnt++;
    end
    #1;
    if (wordValid && !prev_valid) begin
      check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_word = sb_q.pop_front();
        check_eq("sb_word", 32'(word), 32'(sb_word));
      end
    end
    prev_valid = wordValid;
    check_outputs("press");
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, ".valid"},   32'(wordValid), 32'd0);
    check_eq({tag, ".word"},    32'(word),      32'd0);
    check_eq({tag, ".partial"}, 32'(partial),   32'd0);
    check_eq({tag, ".bitcnt"},  32'(bitCount),  32'd0);
    check_eq({tag, ".wordcnt"}, 32'(wordCount), 32'd0);
    check_eq({tag, ".overrun"}, 32'(overrun),   32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int unsigned guard;
    model_reset();
    pat = 16'b1010_0101_1100_0011;

    // 1. Reset and fill
    async_reset("reset0");
    for (int i = 15; i >= 0; i--) press(pat[i], 1'b0, 1'b0);
    check_eq("t1_word", 32'(word), 32'h0000_A5C3);
    check_eq("t1_valid", 32'(wordValid), 32'd1);
    // Clear while holding with ready low: no overrun, word kept
    press(1'b1, 1'b1, 1'b0);
    check_eq("t1_clr_overrun", 32'(overrun), 32'd0);
    check_eq("t1_clr_word", 32'(word), 32'h0000_A5C3);

    // 2. Accept with carry-in bit
    press(1'b1, 1'b0, 1'b1);
    check_eq("t2_partial", 32'(partial), 32'h0000_0001);
    check_eq("t2_bitcnt", 32'(bitCount), 32'd1);
    check_eq("t2_wordcnt", 32'(wordCount), 32'd1);
    for (int i = 0; i < 15; i++) press(1'b0, 1'b0, 1'b0);
    check_eq("t2_word", 32'(word), 32'h0000_8000);

    // 3. Overrun while pending
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
    check_eq("t3_overrun", 32'(overrun), 32'd1);
    check_eq("t3_word", 32'(word), 32'h0000_8000);
    check_eq("t3_partial", 32'(partial), 32'd0);
    // Accept together with clear: next word starts from zero bits
    press(1'b1, 1'b1, 1'b1);
    check_eq("t3_wordcnt", 32'(wordCount), 32'd2);
    check_eq("t3_overrun_sticky", 32'(overrun), 32'd1);
    check_eq("t3_bitcnt", 32'(bitCount), 32'd0);

    // 4. Clear mid-word
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
    check_eq("t4_partial", 32'(partial), 32'h0000_001F);
    check_eq("t4_bitcnt", 32'(bitCount), 32'd5);
    press(1'b1, 1'b1, 1'b0);
    check_eq("t4_clr_partial", 32'(partial), 32'd0);
    check_eq("t4_clr_bitcnt", 32'(bitCount), 32'd0);
    for (int i = 0; i < 16; i++) press(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_eq("t4_valid", 32'(wordValid), 32'd1);
    press(1'b0, 1'b0, 1'b1);

    // 5. Async reset mid-word, then mid-HOLD
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 1'b0);
    check_eq("t5_bitcnt", 32'(bitCount), 32'd7);
    async_reset("t5_midword");
    for (int i = 0; i < 16; i++) press(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check_eq("t5_valid", 32'(wordValid), 32'd1);
    async_reset("t5_midhold");

    // 6. 256 fill/accept cycles wrap the counter
    for (int n = 0; n < 256; n++) begin
      guard = 0;
      while (!m_hold && guard < 20) begin
        press(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        guard++;
      end
      check_eq("t6_fill_bound", 32'(guard < 20), 32'd1);
      press(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    check_eq("t6_wordcnt_wrap", 32'(wordCount), 32'd0);
    check_eq("t6_valid", 32'(wordValid), 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
